sprite_motion_ctrl: RTL and testbench

//  Frame-synchronous position controller for the 16x16 tilt-driven sprite.

---
 rtl/vga_pkg.sv | 18 +
 rtl/axis_clamp.sv | 27 ++
 rtl/sprite_motion_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, sprite-update FSM encoding and wall-hit bit positions.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        WAIT_VB = 2'd0,
        CALC    = 2'd1,
        CLAMP   = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    // Bit positions inside hit = {top, bottom, right, left}
    localparam int HIT_LEFT   = 0;
    localparam int HIT_RIGHT  = 1;
    localparam int HIT_BOTTOM = 2;
    localparam int HIT_TOP    = 3;
endpackage

// File: rtl/axis_clamp.sv
// Clamps one signed 12-bit candidate coordinate into [LO, HI] and flags which bound was hit.
module axis_clamp #(
    parameter int LO = 0,
    parameter int HI = 639
) (
    input  logic signed [11:0] pos_in,
    output logic        [9:0]  pos_out,
    output logic               lo_hit,
    output logic               hi_hit
);
    localparam logic signed [11:0] LO_S = 12'(LO);
    localparam logic signed [11:0] HI_S = 12'(HI);

    // Signed compare, so any negative candidate lands on the low bound.
    always_comb begin
        pos_out = pos_in[9:0];
        lo_hit  = 1'b0;
        hi_hit  = 1'b0;
        if (pos_in < LO_S) begin
            pos_out = LO_S[9:0];
            lo_hit  = 1'b1;
        end else if (pos_in > HI_S) begin
            pos_out = HI_S[9:0];
            hi_hit  = 1'b1;
        end
    end
endmodule

// File: rtl/sprite_motion_ctrl.sv
// Integrates tilt into the 16x16 sprite box once per frame at vblank start, clamps it to the
// playfield, and counts debounced wall contacts.
module sprite_motion_ctrl
    import vga_pkg::*;
#(
    parameter int X_MIN      = 55,
    parameter int X_MAX      = 560,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 479,
    parameter int SPRITE_W   = 16,
    parameter int SPRITE_H   = 16,
    parameter int X_INIT     = 311,
    parameter int Y_INIT     = 231,
    parameter int TILT_SHIFT = 4,
    parameter int DEBOUNCE   = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic signed [9:0] tilt_x,
    input  logic signed [9:0] tilt_y,
    input  logic              tilt_valid,
    output logic              tilt_ready,
    input  logic        [9:0] col,
    input  logic        [9:0] row,
    output logic        [9:0] pixel_x1,
    output logic        [9:0] pixel_x2,
    output logic        [9:0] pixel_y1,
    output logic        [9:0] pixel_y2,
    output logic        [3:0] hit,
    output logic        [9:0] count
);
    localparam int              DEB_W    = $clog2(DEBOUNCE + 1);
    localparam logic [DEB_W-1:0] DEB_FULL = DEB_W'(DEBOUNCE);
    localparam logic [9:0]      VB_ROW   = 10'(Y_MAX + 1);

    state_t              state_q, state_nxt;
    logic                vb_tick;
    logic signed [9:0]   tilt_x_q, tilt_y_q;
    logic signed [11:0]  nx_p0, ny_p0;
    logic        [9:0]   x_cl, y_cl;
    logic                x_lo, x_hi, y_lo, y_hi;
    logic        [9:0]   x_p1, y_p1;
    logic        [3:0]   hit_p1;
    logic        [9:0]   x1_q, y1_q, count_q;
    logic        [3:0]   hit_q;
    logic [DEB_W-1:0]    deb_q;

    // Screen coordinates are unsigned, so the position is zero-extended; only tilt is sign-extended.
    function automatic logic signed [11:0] step(input logic [9:0] pos, input logic signed [9:0] tilt);
        logic signed [11:0] vel;
        vel = $signed({{2{tilt[9]}}, tilt}) >>> TILT_SHIFT;
        return $signed({2'b00, pos}) + vel;
    endfunction

    function automatic logic [9:0] sat_inc_count(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [DEB_W-1:0] sat_inc_deb(input logic [DEB_W-1:0] v);
        return (v == DEB_FULL) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_VB;
            vb_tick <= 1'b0;
        end else begin
            state_q <= state_nxt;
            vb_tick <= (row == VB_ROW) && (col == 10'd0);
        end
    end

    always_comb begin
        state_nxt  = state_q;
        tilt_ready = 1'b0;
        case (state_q)
            WAIT_VB: begin
                tilt_ready = 1'b1;
                if (vb_tick) state_nxt = CALC;
            end
            CALC:    state_nxt = CLAMP;
            CLAMP:   state_nxt = COMMIT;
            COMMIT:  state_nxt = WAIT_VB;
            default: state_nxt = WAIT_VB;
        endcase
    end

    // Single-entry latch: a newer sample simply overwrites the older one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tilt_x_q <= '0;
            tilt_y_q <= '0;
        end else if (tilt_valid && tilt_ready) begin
            tilt_x_q <= tilt_x;
            tilt_y_q <= tilt_y;
        end
    end

    axis_clamp #(.LO(X_MIN), .HI(X_MAX - SPRITE_W + 1)) u_clamp_x (
        .pos_in (nx_p0),
        .pos_out(x_cl),
        .lo_hit (x_lo),
        .hi_hit (x_hi)
    );

    axis_clamp #(.LO(Y_MIN), .HI(Y_MAX - SPRITE_H + 1)) u_clamp_y (
        .pos_in (ny_p0),
        .pos_out(y_cl),
        .lo_hit (y_lo),
        .hi_hit (y_hi)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            nx_p0  <= '0;
            ny_p0  <= '0;
            x_p1   <= '0;
            y_p1   <= '0;
            hit_p1 <= '0;
        end else begin
            // p0: unclamped candidate position
            if (state_q == CALC) begin
                nx_p0 <= step(x1_q, tilt_x_q);
                ny_p0 <= step(y1_q, tilt_y_q);
            end
            // p1: clamped position and wall flags
            if (state_q == CLAMP) begin
                x_p1               <= x_cl;
                y_p1               <= y_cl;
                hit_p1[HIT_LEFT]   <= x_lo;
                hit_p1[HIT_RIGHT]  <= x_hi;
                hit_p1[HIT_BOTTOM] <= y_hi;
                hit_p1[HIT_TOP]    <= y_lo;
            end
        end
    end

    // Commit: visible outputs and contact bookkeeping move together, once per frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x1_q    <= 10'(X_INIT);
            y1_q    <= 10'(Y_INIT);
            hit_q   <= '0;
            count_q <= '0;
            deb_q   <= DEB_FULL;
        end else if (state_q == COMMIT) begin
            x1_q  <= x_p1;
            y1_q  <= y_p1;
            hit_q <= hit_p1;
            if (|hit_p1) begin
                if (deb_q == DEB_FULL) count_q <= sat_inc_count(count_q);
                deb_q <= '0;
            end else begin
                deb_q <= sat_inc_deb(deb_q);
            end
        end
    end

    assign pixel_x1 = x1_q;
    assign pixel_y1 = y1_q;
    assign pixel_x2 = x1_q + 10'(SPRITE_W - 1);
    assign pixel_y2 = y1_q + 10'(SPRITE_H - 1);
    assign hit      = hit_q;
    assign count    = count_q;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Randomized and directed bench for sprite_motion_ctrl with a queue-based scoreboard and a
// per-frame behavioural model of position, wall hits and debounced contact counting.
module tb_sprite_motion_ctrl;
    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic signed [9:0] tilt_x = '0;
    logic signed [9:0] tilt_y = '0;
    logic              tilt_valid = 1'b0;
    logic              tilt_ready;
    logic        [9:0] col = '0;
    logic        [9:0] row = '0;
    logic        [9:0] pixel_x1, pixel_x2, pixel_y1, pixel_y2;
    logic        [3:0] hit;
    logic        [9:0] count;

    sprite_motion_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .tilt_x    (tilt_x),
        .tilt_y    (tilt_y),
        .tilt_valid(tilt_valid),
        .tilt_ready(tilt_ready),
        .col       (col),
        .row       (row),
        .pixel_x1  (pixel_x1),
        .pixel_x2  (pixel_x2),
        .pixel_y1  (pixel_y1),
        .pixel_y2  (pixel_y2),
        .hit       (hit),
        .count     (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x1;
        int y1;
        int hit;
        int count;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp = '{311, 231, 0, 0};
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    // Reference model state: box position, contact counter, frames spent off the walls, tilt latch.
    int m_x = 311, m_y = 231, m_cnt = 0, m_off = 4;
    int lat_x = 0, lat_y = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_x = 311; m_y = 231; m_cnt = 0; m_off = 4;
        lat_x = 0; lat_y = 0;
        last_exp = '{311, 231, 0, 0};
    endtask

    task automatic model_frame();
        int nx, ny, h;
        nx = m_x + (lat_x >>> 4);
        ny = m_y + (lat_y >>> 4);
        h  = 0;
        if (nx < 55) begin nx = 55; h += 1; end
        else if (nx > 545) begin nx = 545; h += 2; end
        if (ny < 0) begin ny = 0; h += 8; end
        else if (ny > 464) begin ny = 464; h += 4; end
        if (h != 0) begin
            if (m_off >= 4 && m_cnt < 1023) m_cnt++;
            m_off = 0;
        end else if (m_off < 4) begin
            m_off++;
        end
        m_x = nx;
        m_y = ny;
        exp_q.push_back('{nx, ny, h, m_cnt});
    endtask

    function automatic int rand_tilt();
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    task automatic drive_sample(input int tx, input int ty);
        tilt_valid = 1'b1;
        tilt_x = 10'(tx);
        tilt_y = 10'(ty);
        lat_x = tx;
        lat_y = ty;
    endtask

    // One compressed 16-cycle frame: active video in cycles 0-7, first vblank pixel in cycle 8.
    task automatic run_frame(input int tx, input int ty, input int nsamp,
                             input bit vb_samp, input bit hold_samp);
        int hx, hy;
        hx = rand_tilt();
        hy = rand_tilt();
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            tilt_valid = 1'b0;
            if (c < 8) begin
                row = 10'd100;
                col = 10'(c * 10);
            end else begin
                row = 10'd480;
                col = 10'(c - 8);
            end
            if (c < nsamp) begin
                if (c == nsamp - 1 && !vb_samp) drive_sample(tx, ty);
                else drive_sample(rand_tilt(), rand_tilt());
            end
            if (c == 9) begin
                if (vb_samp) drive_sample(tx, ty);
                model_frame();
            end
            if (hold_samp && c >= 10 && c <= 14) begin
                tilt_valid = 1'b1;
                tilt_x = 10'(hx);
                tilt_y = 10'(hy);
                if (c == 13) begin
                    lat_x = hx;
                    lat_y = hy;
                end
            end
            if (c == 10) check("ready_low_busy", int'(tilt_ready), 0);
            if (c == 13) check("ready_high_idle", int'(tilt_ready), 1);
        end
        tilt_valid = 1'b0;
    endtask

    // Monitor: on each first-vblank pixel, outputs must hold for 3 clocks after vb_tick, then update.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            if (mon_en && reset_n && row == 10'd480 && col == 10'd0) begin
                repeat (3) @(posedge clock);
                @(negedge clock);
                check("hold_x1", int'(pixel_x1), last_exp.x1);
                check("hold_y1", int'(pixel_y1), last_exp.y1);
                check("hold_hit", int'(hit), last_exp.hit);
                @(posedge clock);
                @(negedge clock);
                if (exp_q.size() == 0) begin
                    check("scoreboard_nonempty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("x1", int'(pixel_x1), e.x1);
                    check("x2", int'(pixel_x2), e.x1 + 15);
                    check("y1", int'(pixel_y1), e.y1);
                    check("y2", int'(pixel_y2), e.y1 + 15);
                    check("hit", int'(hit), e.hit);
                    check("count", int'(count), e.count);
                    last_exp = e;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        row = 10'd100;
        col = 10'd37;
        repeat (3) @(negedge clock);
        check("rst_x1", int'(pixel_x1), 311);
        check("rst_y1", int'(pixel_y1), 231);
        check("rst_x2", int'(pixel_x2), 326);
        check("rst_y2", int'(pixel_y2), 246);
        check("rst_hit", int'(hit), 0);
        check("rst_count", int'(count), 0);
        check("rst_ready", int'(tilt_ready), 1);
        reset_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        run_frame(64, -32, 1, 1'b0, 1'b0);
        check("move_x1", int'(pixel_x1), 315);
        check("move_y1", int'(pixel_y1), 229);

        // Reset pulse in the middle of an update: no partial commit, latch cleared.
        mon_en = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            tilt_valid = 1'b0;
            row = (c < 8) ? 10'd100 : 10'd480;
            col = (c < 8) ? 10'(c) : 10'(c - 8);
            if (c == 11) begin
                reset_n = 1'b0;
                #1;
                check("midrst_x1", int'(pixel_x1), 311);
                check("midrst_y1", int'(pixel_y1), 231);
                check("midrst_hit", int'(hit), 0);
                check("midrst_count", int'(count), 0);
                check("midrst_ready", int'(tilt_ready), 1);
            end
            if (c == 13) reset_n = 1'b1;
        end
        model_reset();
        mon_en = 1'b1;
        run_frame(0, 0, 0, 1'b0, 1'b0);
        check("no_partial_commit_x1", int'(pixel_x1), 311);

        for (int i = 0; i < 20; i++) run_frame(511, 0, 1, 1'b0, 1'b0);
        check("wall_x1", int'(pixel_x1), 545);
        check("wall_x2", int'(pixel_x2), 560);
        check("wall_hit_right", int'(hit[1]), 1);
        check("wall_count", int'(count), 1);

        c0 = int'(count);
        for (int i = 0; i < 3; i++) run_frame(-32, 0, 1, 1'b0, 1'b0);
        run_frame(511, 0, 1, 1'b0, 1'b0);
        check("debounce3_count", int'(count), c0);
        for (int i = 0; i < 4; i++) run_frame(-32, 0, 1, 1'b0, 1'b0);
        run_frame(511, 0, 1, 1'b0, 1'b0);
        check("debounce4_count", int'(count), c0 + 1);

        for (int i = 0; i < 20; i++) run_frame(-512, -512, 1, 1'b0, 1'b0);
        run_frame(16, 16, 1, 1'b0, 1'b0);
        check("pre_corner_x1", int'(pixel_x1), 56);
        check("pre_corner_y1", int'(pixel_y1), 1);
        for (int i = 0; i < 3; i++) run_frame(0, 0, 1, 1'b0, 1'b0);
        c0 = int'(count);
        run_frame(-512, -512, 1, 1'b0, 1'b0);
        check("corner_x1", int'(pixel_x1), 55);
        check("corner_y1", int'(pixel_y1), 0);
        check("corner_hit", int'(hit), 9);
        check("corner_count", int'(count), c0 + 1);
        run_frame(-512, -512, 1, 1'b0, 1'b0);
        check("corner_pinned_count", int'(count), c0 + 1);

        run_frame(200, 150, 3, 1'b0, 1'b0);
        run_frame(100, -100, 1, 1'b0, 1'b1);
        run_frame(0, 0, 0, 1'b0, 1'b0);
        run_frame(-64, 64, 2, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++)
            run_frame(rand_tilt(), rand_tilt(), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        repeat (4) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
